mem_port_responder: RTL and testbench

//  Responder end of the CPU-side cache port protocol: read/write/mbe/addr/wdata -> resp/rdata.

---
 rtl/mem_port_pkg.sv | 27 ++
 rtl/mem_port_array.sv | 37 +++
 rtl/mem_port_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_port_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the CPU-side cache port responder.
// Optional protocol checking in the responder is enabled by MEM_RESP_CHK_EN.
package mem_port_pkg;

   // Width of the latency counter; covers LATENCY values 1..15.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mresp_state_e;

   typedef logic [31:0] word_t;

   // Byte-lane merge: lanes with mbe[i]=1 take new_word, others keep old_word.
   function automatic word_t merge_bytes(input word_t old_word, input word_t new_word,
                                         input logic [3:0] mbe);
      word_t merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mbe[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_port_array.sv
// Word-wide single-port RAM with per-byte write enables and a registered read.
// The read register clears to zero whenever no read is requested, so its output
// can drive the port's rdata directly.
module mem_port_array
   import mem_port_pkg::*;
#(
   parameter int    DEPTH_LOG2 = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_index,
   output word_t                 rd_data,
   input  logic                  wr_en,
   input  logic [3:0]            wr_be,
   input  logic [DEPTH_LOG2-1:0] wr_index,
   input  word_t                 wr_data
);

   word_t mem [0:(1 << DEPTH_LOG2) - 1];

   // Registered read: loads the addressed word when requested, otherwise returns to zero.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_index];
      else       rd_data <= '0;
   end

   // Byte-enabled write: only enabled lanes of the addressed word change.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_port_responder.sv
// Responder end of the CPU-side cache port: fixed-latency word memory model.
// A request sampled in IDLE produces a one-cycle resp exactly LATENCY cycles later;
// dropping the request before then abandons it. Define MEM_RESP_CHK_EN to add the
// err output and protocol checks (illegal requests complete with err, no write, rdata=0).
module mem_port_responder
   import mem_port_pkg::*;
#(
   parameter int    DEPTH_LOG2 = 10,
   parameter int    LATENCY    = 2,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  mbe,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp,
   output logic [31:0] rdata
`ifdef MEM_RESP_CHK_EN
   ,
   output logic        err
`endif
);

   mresp_state_e            state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;

   // Request latch, captured when a request is accepted in IDLE.
   logic                    kind_write_reg;
   logic [DEPTH_LOG2-1:0]   index_reg;
   logic [3:0]              mbe_reg;
   word_t                   wdata_reg;
   logic                    bad_reg;

   logic                    req;
   logic                    bad_in;
   logic [DEPTH_LOG2-1:0]   index_in;
   logic                    sel_write;
   logic                    sel_bad;
   logic [DEPTH_LOG2-1:0]   sel_index;
   logic                    enter_resp;
   logic                    rd_en;
   logic                    wr_en;

   // Upper address bits alias and the byte offset is ignored for word access.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

   assign req      = read | write;
   assign index_in = addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_CHK_EN
   logic mbe_ok;

   // Legal write lane patterns: single bytes, aligned halves, full word.
   always_comb begin
      case (mbe)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: mbe_ok = 1'b1;
         default:                   mbe_ok = 1'b0;
      endcase
   end

   assign bad_in = (read & write) | (|addr[31:DEPTH_LOG2+2]) | (write & ~mbe_ok);
`else
   assign bad_in = 1'b0;
`endif

   // In IDLE the live inputs describe the transaction (needed when LATENCY=1
   // jumps straight to RESP); afterwards only the latched copy is used.
   assign sel_write = (state_reg == IDLE) ? write    : kind_write_reg;
   assign sel_bad   = (state_reg == IDLE) ? bad_in   : bad_reg;
   assign sel_index = (state_reg == IDLE) ? index_in : index_reg;

   // Next-state logic: cnt counts cycles since sampling and reaches LATENCY on the edge into RESP.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               cnt_next   = CNT_W'(1);
               state_next = (cnt_next == CNT_W'(LATENCY)) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!req) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
               if (cnt_next == CNT_W'(LATENCY)) state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign enter_resp = (state_next == RESP) && (state_reg != RESP);

   // Reads load the array's output register on the edge into RESP; writes commit
   // on the edge leaving RESP. Reset at either edge cancels the access.
   assign rd_en = rst && enter_resp && !sel_write && !sel_bad;
   assign wr_en = rst && (state_reg == RESP) && kind_write_reg && !bad_reg;

   // State, counter and the registered resp pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         resp      <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         resp      <= enter_resp;
      end
   end

   // Request latch: fields are frozen at acceptance, later input changes are ignored.
   always_ff @(posedge clk) begin
      if (state_reg == IDLE && req) begin
         kind_write_reg <= write;
         index_reg      <= index_in;
         mbe_reg        <= mbe;
         wdata_reg      <= wdata;
         bad_reg        <= bad_in;
      end
   end

`ifdef MEM_RESP_CHK_EN
   // err accompanies resp for a transaction that failed its sample-time checks.
   always_ff @(posedge clk) begin
      if (!rst) err <= 1'b0;
      else      err <= enter_resp && sel_bad;
   end

   // Flag illegal requests in simulation at the moment they are sampled.
   always_ff @(posedge clk) begin
      if (rst && state_reg == IDLE && req) begin
         assert (!bad_in)
         else $error("mem_port_responder: illegal request addr=%h mbe=%b read=%b write=%b",
                     addr, mbe, read, write);
      end
   end
`endif

   mem_port_array #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk      (clk),
      .rd_en    (rd_en),
      .rd_index (sel_index),
      .rd_data  (rdata),
      .wr_en    (wr_en),
      .wr_be    (mbe_reg),
      .wr_index (index_reg),
      .wr_data  (wdata_reg)
   );

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: three instances with LATENCY 1, 2 and 3 share clock
// and reset; a word-array reference model predicts rdata and memory contents.
// Builds with or without MEM_RESP_CHK_EN.
module tb_mem_port_responder;

   localparam int DL2   = 6;
   localparam int DEPTH = 1 << DL2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_i    [3];
   logic        wr_i    [3];
   logic [3:0]  mbe_i   [3];
   logic [31:0] addr_i  [3];
   logic [31:0] wdata_i [3];
   logic        resp_o  [3];
   logic [31:0] rdata_o [3];
`ifdef MEM_RESP_CHK_EN
   logic        err_o   [3];
`endif

   int errors = 0;
   int checks = 0;

   // Reference memory per instance, indexed by word.
   logic [31:0] model [3][DEPTH];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mem_port_responder #(
         .DEPTH_LOG2 (DL2),
         .LATENCY    (gi + 1),
         .INIT_FILE  ("")
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .read  (rd_i[gi]),
         .write (wr_i[gi]),
         .mbe   (mbe_i[gi]),
         .addr  (addr_i[gi]),
         .wdata (wdata_i[gi]),
         .resp  (resp_o[gi]),
         .rdata (rdata_o[gi])
`ifdef MEM_RESP_CHK_EN
         ,
         .err   (err_o[gi])
`endif
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic bit is_bad(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [3:0] be);
`ifdef MEM_RESP_CHK_EN
      bit be_ok;
      be_ok = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
              (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
      return (rd && wr) || ((a >> (DL2 + 2)) != 0) || (wr && !be_ok);
`else
      return 1'b0 & rd & wr & (a != 0) & (be != 0);
`endif
   endfunction

   // One complete transaction on instance n, started at a negedge with the responder idle.
   task automatic txn(input int n, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, output logic [31:0] got);
      int          lat = n + 1;
      int          ix  = widx(a);
      bit          bad = is_bad(rd, wr, a, be);
      logic [31:0] exp_rd;
      exp_rd = (rd && !wr && !bad) ? model[n][ix] : 32'h0;
      got = 32'h0;
      rd_i[n] = rd; wr_i[n] = wr; addr_i[n] = a; wdata_i[n] = wd; mbe_i[n] = be;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("resp L%0d a=%h k=%0d", lat, a, k), 32'(resp_o[n]), 32'(k == lat));
         if (k == lat) begin
            got = rdata_o[n];
            check($sformatf("rdata L%0d a=%h", lat, a), rdata_o[n], exp_rd);
`ifdef MEM_RESP_CHK_EN
            check($sformatf("err L%0d a=%h", lat, a), 32'(err_o[n]), 32'(bad));
`endif
         end else if (k == 1) begin
            // Fields were latched at sampling; disturbing them must not matter.
            addr_i[n] = $urandom; wdata_i[n] = $urandom; mbe_i[n] = 4'($urandom);
         end
      end
      rd_i[n] = 1'b0; wr_i[n] = 1'b0;
      @(posedge clk); @(negedge clk);
      check($sformatf("resp_after L%0d", lat), 32'(resp_o[n]), 32'h0);
      check($sformatf("rdata_after L%0d", lat), rdata_o[n], 32'h0);
      if (wr && !bad) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) model[n][ix][8*i +: 8] = wd[8*i +: 8];
         end
      end
      $display("txn L%0d rd=%0b wr=%0b addr=%h wdata=%h mbe=%b rdata=%h",
               lat, rd, wr, a, wd, be, got);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] val;

      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         rd_i[n] = 1'b0; wr_i[n] = 1'b0; mbe_i[n] = 4'h0; addr_i[n] = 32'h0; wdata_i[n] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         check($sformatf("reset resp %0d", n), 32'(resp_o[n]), 32'h0);
         check($sformatf("reset rdata %0d", n), rdata_o[n], 32'h0);
      end
      rst = 1'b1;
      @(negedge clk);

      // Full write then read back at LATENCY=2.
      txn(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, got);
      txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, got);
      check("readback 0x10", got, 32'hDEADBEEF);

      // Byte merge.
      txn(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, got);
      txn(1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, got);
      txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, got);
      check("merge 0x20", got, 32'h11BB33DD);

      // Empty byte mask, read+write together, aliasing and byte offset.
      txn(1, 1'b0, 1'b1, 32'h4, 32'h01020304, 4'b1111, got);
      txn(1, 1'b0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0000, got);
      txn(1, 1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 4'b1111, got);
      txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'b0000, got);
      txn(1, 1'b0, 1'b1, 32'h110, 32'h55AA55AA, 4'b1111, got);
      txn(1, 1'b1, 1'b0, 32'h13, 32'h0, 4'b0000, got);

      // Abort at LATENCY=3: read held one cycle then dropped, no resp afterwards.
      txn(2, 1'b0, 1'b1, 32'h40, 32'h600DCAFE, 4'b1111, got);
      rd_i[2] = 1'b1; addr_i[2] = 32'h40;
      @(posedge clk); @(negedge clk);
      rd_i[2] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("abort no resp k=%0d", k), 32'(resp_o[2]), 32'h0);
      end
      txn(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, got);

      // Reset during WAIT of a write: no resp, word unchanged, responder idle afterwards.
      txn(2, 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'b1111, got);
      wr_i[2] = 1'b1; addr_i[2] = 32'h30; wdata_i[2] = 32'h12345678; mbe_i[2] = 4'b1111;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rst mid-write resp", 32'(resp_o[2]), 32'h0);
      rst = 1'b1; wr_i[2] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("post-rst no resp k=%0d", k), 32'(resp_o[2]), 32'h0);
      end
      txn(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, got);
      check("rst word kept", got, 32'h0BADF00D);

      // Back-to-back reads at LATENCY=1: pulses on every other cycle.
      txn(0, 1'b0, 1'b1, 32'h8, 32'hA5A5C3C3, 4'b1111, got);
      val = model[0][widx(32'h8)];
      rd_i[0] = 1'b1; addr_i[0] = 32'h8;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("b2b resp k=%0d", k), 32'(resp_o[0]), 32'(k % 2));
         check($sformatf("b2b rdata k=%0d", k), rdata_o[0], (k % 2 == 1) ? val : 32'h0);
         $display("b2b k=%0d resp=%0b rdata=%h", k, resp_o[0], rdata_o[0]);
      end
      rd_i[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      check("b2b end resp", 32'(resp_o[0]), 32'h0);

      // Randomized traffic at LATENCY=2 over a fully initialised memory.
      for (int w = 0; w < DEPTH; w++) begin
         txn(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'b1111, got);
      end
      for (int r = 0; r < 60; r++) begin
         bit          rd;
         bit          wr;
         logic [31:0] a;
         rd = 1'($urandom);
         wr = !rd || ($urandom_range(0, 7) == 0);
         a  = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
         txn(1, rd, wr, a, $urandom, 4'($urandom), got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
